// File: rtl/rns_rev_conv_4051.sv
// Residue-to-binary converter for the RNS {4051, 4096}.
// Mixed-radix rebuild x = r_p + 4096*k with k formed by MSB-first shift-add.
module rns_rev_conv_4051 #(
  parameter int MOD = 4051,
  parameter int W   = 12,
  parameter int INV = 3961
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   r_m,
  input  logic [W-1:0]   r_p,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_x,
  output logic           out_err
);

  localparam int IW = $clog2(W);
  localparam logic [W:0]   MODW = (W+1)'(MOD);
  localparam logic [W-1:0] INVW = W'(INV);

  typedef enum logic [1:0] {
    IDLE, DIFF, MUL, DONE
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]   rm_q, rm_d;
  logic [W-1:0]   rp_q, rp_d;
  logic           err_q, err_d;
  logic [W-1:0]   d_q, d_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [IW-1:0]  i_q, i_d;
  logic           ov_q, ov_d;
  logic [2*W-1:0] ox_q, ox_d;
  logic           oe_q, oe_d;

  logic [W:0] rp_red, d_full;
  logic [W:0] a2, a2r, sum, sumr, acc_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rm_q    <= '0;
      rp_q    <= '0;
      err_q   <= 1'b0;
      d_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      ov_q    <= 1'b0;
      ox_q    <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rm_q    <= rm_d;
      rp_q    <= rp_d;
      err_q   <= err_d;
      d_q     <= d_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      ov_q    <= ov_d;
      ox_q    <= ox_d;
      oe_q    <= oe_d;
    end
  end

  // All compares happen before subtracts, in W+1 bits, so nothing wraps.
  always_comb begin
    rp_red = ({1'b0, rp_q} >= MODW) ? {1'b0, rp_q} - MODW
                                    : {1'b0, rp_q};
    d_full = ({1'b0, rm_q} >= rp_red) ? {1'b0, rm_q} - rp_red
                                      : {1'b0, rm_q} + MODW - rp_red;
    a2     = {acc_q, 1'b0};
    a2r    = (a2 >= MODW) ? a2 - MODW : a2;
    sum    = a2r + {1'b0, d_q};
    sumr   = (sum >= MODW) ? sum - MODW : sum;
    acc_nx = INVW[i_q] ? sumr : a2r;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = DIFF;
      DIFF: state_d = err_q ? DONE : MUL;
      MUL:  if (i_q == '0) state_d = DONE;
      DONE: if (ov_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rm_d  = rm_q;
    rp_d  = rp_q;
    err_d = err_q;
    d_d   = d_q;
    acc_d = acc_q;
    i_d   = i_q;
    ov_d  = ov_q;
    ox_d  = ox_q;
    oe_d  = oe_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          rm_d  = r_m;
          rp_d  = r_p;
          err_d = ({1'b0, r_m} >= MODW);
        end
      end
      DIFF: begin
        d_d   = d_full[W-1:0];
        acc_d = '0;
        i_d   = IW'(W-1);
      end
      MUL: begin
        acc_d = acc_nx[W-1:0];
        if (i_q != '0) i_d = i_q - IW'(1);
      end
      DONE: begin
        // First DONE cycle loads the output register; later ones wait.
        if (!ov_q) begin
          ov_d = 1'b1;
          ox_d = err_q ? '0 : {acc_q, rp_q};
          oe_d = err_q;
        end else if (out_ready) begin
          ov_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = ov_q;
    out_x     = ox_q;
    out_err   = oe_q;
  end

endmodule
